life_state_engine: RTL and testbench

//  Holds the current Game-of-Life generation in a register bank and drives it into the combinational

---
 rtl/life_pkg.sv | 18 +
 rtl/life_row_loader.sv | 37 +++
 rtl/life_state_engine.sv | 130 +++++++++++++
 tb/tb_life_state_engine.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// Shared types and helpers for the Game-of-Life state engine and its grid.
package life_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    HALT = 2'd3
  } life_state_t;

  localparam int LIFE_GRID_W = 8;

  // Flat bit position of cell (x, y) in a row-major grid word.
  function automatic int cell_index(input int x, input int y, input int w = LIFE_GRID_W);
    return w * y + x;
  endfunction

endpackage

// File: rtl/life_row_loader.sv
// Row-serial loader: tracks the row being written, raises ready while the
// engine is loading and flags the final row so the FSM can return to idle.
module life_row_loader #(
  parameter int GRID_HEIGHT = 8,
  parameter int ROW_W       = 3
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load_active,
  input  logic             i_load_valid,
  output logic             o_load_ready,
  output logic             o_row_we,
  output logic             o_last_row,
  output logic [ROW_W-1:0] o_row_idx
);

  logic [ROW_W-1:0] r_row;

  // Ready follows the LOAD state directly, so it drops the cycle after the final row.
  always_comb begin
    o_load_ready = i_load_active;
    o_row_we     = i_load_active & i_load_valid;
    o_last_row   = o_row_we && (r_row == ROW_W'(GRID_HEIGHT - 1));
    o_row_idx    = r_row;
  end

  // Row counter advances on each accepted row and wraps to 0 after the last.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_row <= '0;
    end else if (o_row_we) begin
      if (o_last_row) r_row <= '0;
      else            r_row <= r_row + ROW_W'(1);
    end
  end

endmodule

// File: rtl/life_state_engine.sv
// Game-of-Life state engine: holds the current generation, captures the
// grid's next-state word on each advance, and sequences load/step/run.
// Optional build macro STABLE_HALT_EN: a stable advance in RUN moves to HALT.
module life_state_engine
  import life_pkg::*;
#(
  parameter int GRID_WIDTH  = 8,
  parameter int GRID_HEIGHT = 8,
  parameter int GEN_WIDTH   = 16
) (
  input  logic                            i_clk,
  input  logic                            i_rst,
  input  logic                            i_load_start,
  input  logic                            i_load_valid,
  output logic                            o_load_ready,
  input  logic [GRID_WIDTH-1:0]           i_load_row,
  input  logic                            i_step,
  input  logic                            i_run,
  input  logic                            i_tick,
  input  logic [GRID_WIDTH*GRID_HEIGHT-1:0] i_grid_next,
  output logic [GRID_WIDTH*GRID_HEIGHT-1:0] o_grid_state,
  output logic [GEN_WIDTH-1:0]            o_generation,
  output logic [1:0]                      o_state,
  output logic                            o_extinct,
  output logic                            o_stable
);

  localparam int ROW_W = (GRID_HEIGHT > 1) ? $clog2(GRID_HEIGHT) : 1;

  life_state_t                       r_state;
  life_state_t                       w_state_nxt;
  logic [GRID_WIDTH*GRID_HEIGHT-1:0] r_grid;
  logic [GEN_WIDTH-1:0]              r_gen;
  logic                              w_advance;
  logic                              w_gen_inc;
  logic                              w_stable;
  logic                              w_row_we;
  logic                              w_last_row;
  logic [ROW_W-1:0]                  w_row_idx;

  life_row_loader #(
    .GRID_HEIGHT (GRID_HEIGHT),
    .ROW_W       (ROW_W)
  ) u_loader (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_load_active (r_state == LOAD),
    .i_load_valid  (i_load_valid),
    .o_load_ready  (o_load_ready),
    .o_row_we      (w_row_we),
    .o_last_row    (w_last_row),
    .o_row_idx     (w_row_idx)
  );

  assign w_stable     = (i_grid_next == r_grid);
  assign o_stable     = w_stable;
  assign o_extinct    = (r_grid == '0);
  assign o_grid_state = r_grid;
  assign o_generation = r_gen;
  assign o_state      = r_state;

  // Next-state and advance decode; load start outranks step/run in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_advance   = 1'b0;
    w_gen_inc   = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_load_start) begin
          w_state_nxt = LOAD;
        end else if (i_step) begin
          w_advance = 1'b1;
          w_gen_inc = 1'b1;
        end else if (i_run) begin
          w_state_nxt = RUN;
        end
      end
      LOAD: begin
        if (w_last_row) w_state_nxt = IDLE;
      end
      RUN: begin
        if (!i_run) begin
          w_state_nxt = IDLE;
        end else if (i_tick) begin
          w_advance = 1'b1;
`ifdef STABLE_HALT_EN
          // The halting advance rewrites identical contents but is not counted.
          if (w_stable) w_state_nxt = HALT;
          else          w_gen_inc   = 1'b1;
`else
          w_gen_inc = 1'b1;
`endif
        end
      end
      HALT: begin
        if (!i_run) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Generation bank: whole-word capture on advance, one row per accepted load beat.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_grid <= '0;
    end else if (w_advance) begin
      r_grid <= i_grid_next;
    end else if (w_row_we) begin
      r_grid[cell_index(0, int'(w_row_idx), GRID_WIDTH) +: GRID_WIDTH] <= i_load_row;
    end
  end

  // Generation counter: cleared by a completed load, saturates instead of wrapping.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_gen <= '0;
    end else if (w_last_row) begin
      r_gen <= '0;
    end else if (w_gen_inc && (r_gen != '1)) begin
      r_gen <= r_gen + GEN_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_life_state_engine.sv
// Bench for life_state_engine: an 8x8 Life neighbourhood stands in for the
// grid, and a cycle-level reference model tracks state, grid and counters.
module tb_life_state_engine;

  localparam int W = 8;
  localparam int H = 8;
`ifdef STABLE_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        load_start = 0, load_valid = 0, step = 0, run = 0, tick = 0;
  logic [7:0]  load_row = '0;
  logic [63:0] gnext_a, gstate_a, gnext_b, gstate_b;
  logic        ready_a, ready_b, ext_a, ext_b, stb_a, stb_b;
  logic [15:0] gen_a;
  logic [3:0]  gen_b;
  logic [1:0]  st_a, st_b;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state
  int          m_st, m_row, m_gen_a, m_gen_b;
  logic [63:0] m_grid;

  // Conway's rules on a bounded 8x8 field (cells outside are dead).
  function automatic logic [63:0] life(input logic [63:0] s);
    logic [63:0] r;
    int n;
    r = '0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        n = 0;
        for (int dy = -1; dy <= 1; dy++)
          for (int dx = -1; dx <= 1; dx++)
            if ((dx != 0 || dy != 0) && x + dx >= 0 && x + dx < W && y + dy >= 0 && y + dy < H)
              n += int'(s[(y + dy) * W + x + dx]);
        r[y * W + x] = (n == 3) || (n == 2 && s[y * W + x]);
      end
    end
    return r;
  endfunction

  always_comb gnext_a = life(gstate_a);
  always_comb gnext_b = life(gstate_b);

  life_state_engine #(.GRID_WIDTH(8), .GRID_HEIGHT(8), .GEN_WIDTH(16)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_load_valid(load_valid),
    .o_load_ready(ready_a), .i_load_row(load_row), .i_step(step), .i_run(run), .i_tick(tick),
    .i_grid_next(gnext_a), .o_grid_state(gstate_a), .o_generation(gen_a), .o_state(st_a),
    .o_extinct(ext_a), .o_stable(stb_a)
  );

  life_state_engine #(.GRID_WIDTH(8), .GRID_HEIGHT(8), .GEN_WIDTH(4)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_load_start(load_start), .i_load_valid(load_valid),
    .o_load_ready(ready_b), .i_load_row(load_row), .i_step(step), .i_run(run), .i_tick(tick),
    .i_grid_next(gnext_b), .o_grid_state(gstate_b), .o_generation(gen_b), .o_state(st_b),
    .o_extinct(ext_b), .o_stable(stb_b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_all();
    chk("state",   64'(st_a),   64'(m_st));
    chk("grid",    gstate_a,    m_grid);
    chk("gen",     64'(gen_a),  64'(m_gen_a));
    chk("ready",   64'(ready_a), 64'(m_st == 1));
    chk("extinct", 64'(ext_a),  64'(m_grid == 64'd0));
    chk("stable",  64'(stb_a),  64'(life(m_grid) == m_grid));
    chk("b_state", 64'(st_b),   64'(m_st));
    chk("b_grid",  gstate_b,    m_grid);
    chk("b_gen",   64'(gen_b),  64'(m_gen_b));
    chk("b_ready", 64'(ready_b), 64'(m_st == 1));
  endtask

  // Advance the model by one clock from the currently driven inputs, then compare.
  task automatic cyc();
    int ns, nr, ga, gb;
    logic [63:0] ng;
    bit adv, inc;
    ns = m_st; nr = m_row; ga = m_gen_a; gb = m_gen_b; ng = m_grid;
    adv = 0; inc = 0;
    case (m_st)
      0: if (load_start) ns = 1;
         else if (step) begin adv = 1; inc = 1; end
         else if (run) ns = 2;
      1: if (load_valid) begin
           ng[m_row * W +: W] = load_row;
           if (m_row == H - 1) begin nr = 0; ga = 0; gb = 0; ns = 0; end
           else nr = m_row + 1;
         end
      2: if (!run) ns = 0;
         else if (tick) begin
           adv = 1;
           if (HALT_EN && life(m_grid) == m_grid) ns = 3;
           else inc = 1;
         end
      default: if (!run) ns = 0;
    endcase
    if (adv) ng = life(m_grid);
    if (inc) begin
      if (ga < 65535) ga++;
      if (gb < 15) gb++;
    end
    @(posedge clk);
    #1;
    m_st = ns; m_row = nr; m_gen_a = ga; m_gen_b = gb; m_grid = ng;
    compare_all();
  endtask

  // Asynchronous reset between clock edges; outputs must clear immediately.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    m_st = 0; m_row = 0; m_gen_a = 0; m_gen_b = 0; m_grid = '0;
    compare_all();
    chk("rst_extinct", 64'(ext_a), 64'd1);
    chk("rst_stable",  64'(stb_a), 64'd1);
    #1;
    rst = 1'b0;
  endtask

  task automatic load_rows(input logic [63:0] pat);
    load_valid = 1'b1;
    for (int r = 0; r < H; r++) begin
      load_row = pat[r * W +: W];
      cyc();
    end
    load_valid = 1'b0;
  endtask

  task automatic load(input logic [63:0] pat);
    load_start = 1'b1;
    cyc();
    load_start = 1'b0;
    load_rows(pat);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    #2;
    do_reset();

    // Reset in the middle of a load
    load_start = 1'b1; cyc(); load_start = 1'b0;
    load_valid = 1'b1;
    for (int r = 0; r < 3; r++) begin
      load_row = 8'(r + 8'hA5); cyc();
    end
    do_reset();
    load_valid = 1'b0;
    chk("midload_rst_grid", gstate_a, 64'd0);

    // Blinker load and two single steps
    load(64'h0000_0000_001C_0000);
    chk("blinker_load", gstate_a, 64'h0000_0000_001C_0000);
    step = 1'b1; cyc(); step = 1'b0;
    chk("blinker_vert", gstate_a, 64'h0000_0000_0808_0800);
    step = 1'b1; cyc(); step = 1'b0;
    chk("blinker_horiz", gstate_a, 64'h0000_0000_001C_0000);
    chk("blinker_gen2", 64'(gen_a), 64'd2);

    // Load start beats step in the same cycle
    load_start = 1'b1; step = 1'b1; cyc(); load_start = 1'b0; step = 1'b0;
    chk("start_step_state", 64'(st_a), 64'd1);
    chk("start_step_noadv", gstate_a, 64'h0000_0000_001C_0000);

    // Glider, free-run with a tick every third cycle
    load_rows(64'h0000_0000_0007_0402);
    run = 1'b1; cyc();
    for (int i = 0; i < 36; i++) begin
      tick = (i % 3 == 2); cyc();
    end
    tick = 1'b0; run = 1'b0; cyc();
    chk("glider_shift", gstate_a, 64'h0000_3820_1000_0000);
    chk("glider_gen", 64'(gen_a), 64'd12);

    // Still-life block under free-run
    load(64'h0000_0000_0006_0600);
    run = 1'b1; tick = 1'b1;
    for (int i = 0; i < 4; i++) cyc();
    chk("block_state", 64'(st_a), HALT_EN ? 64'd3 : 64'd2);
    chk("block_gen", 64'(gen_a), HALT_EN ? 64'd0 : 64'd3);
    run = 1'b0; tick = 1'b0; cyc();

    // Saturation of the narrow counter, then extinction of a lone cell
    load(64'h0000_0000_001C_0000);
    run = 1'b1; cyc();
    tick = 1'b1;
    for (int i = 0; i < 20; i++) cyc();
    chk("sat_gen_b", 64'(gen_b), 64'hF);
    chk("sat_gen_a", 64'(gen_a), 64'd20);
    run = 1'b0; tick = 1'b0; cyc();
    load(64'h0000_0000_0800_0000);
    chk("lone_alive", 64'(ext_a), 64'd0);
    step = 1'b1; cyc(); step = 1'b0;
    chk("lone_extinct", 64'(ext_a), 64'd1);
    chk("lone_extinct_b", 64'(ext_b), 64'd1);

    // Randomized control traffic against the model
    for (int i = 0; i < 3000; i++) begin
      load_start = ($urandom_range(0, 39) == 0);
      load_valid = $urandom_range(0, 1) == 1;
      load_row   = 8'($urandom);
      step       = ($urandom_range(0, 7) == 0);
      if ($urandom_range(0, 15) == 0) run = ~run;
      tick       = $urandom_range(0, 1) == 1;
      cyc();
      if ($urandom_range(0, 499) == 0) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
